// File: rtl/ctr_run_ctrl.sv
// Run controller for the counter model: accepts a run command, pulses the counter
// reset, counts RUN cycles until done or timeout, then returns the result.
module ctr_run_ctrl #(
    parameter int unsigned MAX_WIDTH  = 32,
    parameter int unsigned TO_WIDTH   = 32,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MAX_WIDTH-1:0] cmd_max,
    input  logic [TO_WIDTH-1:0]  cmd_timeout,
    output logic                 dut_reset_l,
    output logic [MAX_WIDTH-1:0] dut_max,
    input  logic                 dut_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MAX_WIDTH-1:0] rsp_cycles,
    output logic                 rsp_timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned CMP_W = (MAX_WIDTH > TO_WIDTH) ? MAX_WIDTH : TO_WIDTH;

    localparam logic [RC_W-1:0]      RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [RC_W-1:0]      RC_ONE  = RC_W'(1);
    localparam logic [RC_W-1:0]      RC_ZERO = RC_W'(0);
    localparam logic [MAX_WIDTH-1:0] K_ONE   = MAX_WIDTH'(1);
    localparam logic [MAX_WIDTH-1:0] K_ZERO  = MAX_WIDTH'(0);
    localparam logic [TO_WIDTH-1:0]  TO_ZERO = TO_WIDTH'(0);

    logic [1:0]           r_state;
    logic                 r_cmd_ready;
    logic                 r_dut_reset_l;
    logic [MAX_WIDTH-1:0] r_dut_max;
    logic [TO_WIDTH-1:0]  r_timeout;
    logic [MAX_WIDTH-1:0] r_k;
    logic [RC_W-1:0]      r_rst_cnt;
    logic                 r_rsp_valid;
    logic [MAX_WIDTH-1:0] r_rsp_cycles;
    logic                 r_rsp_timeout;

    logic                 w_accept;
    logic                 w_to_hit;
    logic                 w_k_sat;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_k_sat  = &r_k;
    // Compare in a common width so mismatched MAX/TO widths still line up.
    assign w_to_hit = (r_timeout != TO_ZERO) && (CMP_W'(r_k) == CMP_W'(r_timeout));

    // Run sequencer: state and every output register advance together.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_dut_reset_l <= 1'b0;
            r_dut_max     <= K_ZERO;
            r_timeout     <= TO_ZERO;
            r_k           <= K_ZERO;
            r_rst_cnt     <= RC_ZERO;
            r_rsp_valid   <= 1'b0;
            r_rsp_cycles  <= K_ZERO;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dut_reset_l <= 1'b0;
                    if (w_accept) begin
                        r_state     <= S_RST;
                        r_cmd_ready <= 1'b0;
                        r_dut_max   <= cmd_max;
                        r_timeout   <= cmd_timeout;
                        r_k         <= K_ZERO;
                        r_rst_cnt   <= RC_ZERO;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_RST: begin
                    if (r_rst_cnt == RC_LAST) begin
                        r_state       <= S_RUN;
                        r_dut_reset_l <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_ONE;
                    end
                end
                S_RUN: begin
                    // done wins over timeout when both land on the same cycle
                    if (dut_done) begin
                        r_state       <= S_RESP;
                        r_dut_reset_l <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_cycles  <= r_k;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_to_hit) begin
                        r_state       <= S_RESP;
                        r_dut_reset_l <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_cycles  <= r_k;
                        r_rsp_timeout <= 1'b1;
                    end else if (!w_k_sat) begin
                        r_k <= r_k + K_ONE;
                    end else begin
                        r_k <= r_k;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cmd_ready   <= 1'b0;
                    r_dut_reset_l <= 1'b0;
                    r_rsp_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign dut_reset_l = r_dut_reset_l;
    assign dut_max     = r_dut_max;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_cycles  = r_rsp_cycles;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_ctr_run_ctrl.sv
// Bench for ctr_run_ctrl: a behavioural counter drives dut_done; runs come from a
// vector table, hand-written corner sequences and random commands.
module tb_ctr_run_ctrl;

    localparam int RST_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_max = 32'd0;
    logic [31:0] cmd_timeout = 32'd0;
    logic        dut_reset_l;
    logic [31:0] dut_max;
    logic        dut_done;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_cycles;
    logic        rsp_timeout;

    int checks = 0;
    int failures = 0;

    ctr_run_ctrl #(.MAX_WIDTH(32), .TO_WIDTH(32), .RST_CYCLES(RST_CYCLES)) u_dut (
        .clk(clk), .reset_l(reset_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_max(cmd_max), .cmd_timeout(cmd_timeout),
        .dut_reset_l(dut_reset_l), .dut_max(dut_max), .dut_done(dut_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // Well-behaved counter: cleared while held in reset, counts up, done at max.
    logic [31:0] ctr;
    always @(posedge clk) begin
        if (dut_reset_l !== 1'b1) ctr <= 32'd0;
        else                      ctr <= ctr + 32'd1;
    end
    assign dut_done = (ctr == dut_max);

    typedef struct {
        logic [31:0] mx;
        logic [31:0] to;
        logic [31:0] exp_c;
        logic        exp_t;
        int          rdelay;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_run(input logic [31:0] mx, input logic [31:0] to,
                          input logic [31:0] exp_c, input logic exp_t,
                          input int rdelay, input string nm);
        int n;
        int lowc;
        int runc;
        logic max_ok;
        logic hold_ok;
        logic [31:0] c0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_max = mx; cmd_timeout = to;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_max = $urandom; cmd_timeout = $urandom;
        chk({nm, ".cmd_ready_busy"}, {31'd0, cmd_ready}, 32'd0);
        lowc = 0; max_ok = 1'b1;
        while (dut_reset_l !== 1'b1 && lowc < 100) begin
            if (dut_max !== mx) max_ok = 1'b0;
            lowc++;
            @(negedge clk);
        end
        chk({nm, ".reset_low_cycles"}, 32'(lowc), 32'(RST_CYCLES));
        runc = 0;
        while (rsp_valid !== 1'b1 && runc < 5000) begin
            if (dut_max !== mx || dut_reset_l !== 1'b1) max_ok = 1'b0;
            runc++;
            @(negedge clk);
        end
        chk({nm, ".run_cycles"}, 32'(runc), exp_c + 32'd1);
        chk({nm, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({nm, ".rsp_cycles"}, rsp_cycles, exp_c);
        chk({nm, ".rsp_timeout"}, {31'd0, rsp_timeout}, {31'd0, exp_t});
        chk({nm, ".dut_reset_l_resp"}, {31'd0, dut_reset_l}, 32'd0);
        chk({nm, ".dut_max_held"}, {31'd0, max_ok}, 32'd1);
        hold_ok = 1'b1; c0 = rsp_cycles;
        for (int i = 0; i < rdelay; i++) begin
            cmd_valid = 1'b1; cmd_max = 32'd99; cmd_timeout = 32'd0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_cycles !== c0 || rsp_timeout !== exp_t ||
                cmd_ready !== 1'b0 || dut_max !== mx) hold_ok = 1'b0;
        end
        if (rdelay > 0) chk({nm, ".resp_hold_stable"}, {31'd0, hold_ok}, 32'd1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, ".rsp_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, ".cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
        chk({nm, ".dut_max_after"}, dut_max, mx);
    endtask

    vec_t vecs[$];
    logic quiet_ok;
    logic [31:0] rmx;
    logic [31:0] rto;
    logic [31:0] rexp_c;
    logic        rexp_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{32'd5,   32'd0,  32'd5,  1'b0, 0, "max5"});
        vecs.push_back('{32'd0,   32'd0,  32'd0,  1'b0, 0, "max0"});
        vecs.push_back('{32'd100, 32'd10, 32'd10, 1'b1, 1, "timeout10"});
        vecs.push_back('{32'd10,  32'd10, 32'd10, 1'b0, 0, "done_eq_timeout"});
        vecs.push_back('{32'd4,   32'd0,  32'd4,  1'b0, 7, "resp_hold7"});
        vecs.push_back('{32'd3,   32'd1,  32'd1,  1'b1, 2, "timeout1"});
        vecs.push_back('{32'd1,   32'd1,  32'd1,  1'b0, 0, "max1_to1"});
        vecs.push_back('{32'd7,   32'd8,  32'd7,  1'b0, 3, "done_before_to"});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.cmd_ready",   {31'd0, cmd_ready},   32'd0);
        chk("rst.dut_reset_l", {31'd0, dut_reset_l}, 32'd0);
        chk("rst.dut_max",     dut_max,              32'd0);
        chk("rst.rsp_valid",   {31'd0, rsp_valid},   32'd0);
        chk("rst.rsp_cycles",  rsp_cycles,           32'd0);
        chk("rst.rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        reset_l = 1'b1;
        @(negedge clk);
        chk("rst.cmd_ready_release", {31'd0, cmd_ready}, 32'd1);

        foreach (vecs[i]) do_run(vecs[i].mx, vecs[i].to, vecs[i].exp_c, vecs[i].exp_t,
                                 vecs[i].rdelay, vecs[i].nm);

        // Reset in the middle of a run aborts with no response
        cmd_valid = 1'b1; cmd_max = 32'd50; cmd_timeout = 32'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (RST_CYCLES + 5) @(negedge clk);
        chk("abort.running", {31'd0, dut_reset_l}, 32'd1);
        reset_l = 1'b0;
        @(negedge clk);
        chk("abort.dut_reset_l", {31'd0, dut_reset_l}, 32'd0);
        chk("abort.rsp_valid",   {31'd0, rsp_valid},   32'd0);
        chk("abort.cmd_ready",   {31'd0, cmd_ready},   32'd0);
        chk("abort.dut_max",     dut_max,              32'd0);
        reset_l = 1'b1;
        @(negedge clk);
        chk("abort.cmd_ready_release", {31'd0, cmd_ready}, 32'd1);
        quiet_ok = 1'b1;
        repeat (70) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || dut_reset_l !== 1'b0) quiet_ok = 1'b0;
        end
        chk("abort.no_response", {31'd0, quiet_ok}, 32'd1);
        do_run(32'd3, 32'd0, 32'd3, 1'b0, 0, "after_abort");

        // Random commands against the arithmetic outcome rule
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rmx = 32'($urandom_range(0, 30));
            rto = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
            rexp_t = (rto != 32'd0) && (rto < rmx);
            rexp_c = rexp_t ? rto : rmx;
            do_run(rmx, rto, rexp_c, rexp_t, int'($urandom_range(0, 4)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
